// File: rtl/signed_divider_seq.sv
// Iterative signed fixed-point divider: dout = (din << FRAC) / W, restoring, one quotient bit per clock.
// Build option DIVIDER_ROUND_EN: round half away from zero instead of truncating toward zero.
module signed_divider_seq #(
  parameter int DIN_W = 16,
  parameter int W_W   = 8,
  parameter int FRAC  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIN_W-1:0] din,
  input  logic [W_W-1:0]   W,
  output logic             busy,
  output logic             done,
  output logic [DIN_W-1:0] dout,
  output logic             sat,
  output logic             div_zero
);

  localparam int NUM_W = DIN_W + FRAC;
  localparam int Q_W   = NUM_W + 1;
  localparam int CNT_W = $clog2(NUM_W);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [Q_W-1:0]   POS_LIM  = Q_W'((1 << (DIN_W - 1)) - 1);
  localparam logic [Q_W-1:0]   NEG_LIM  = Q_W'(1 << (DIN_W - 1));
  localparam logic [DIN_W-1:0] SAT_POS  = {1'b0, {(DIN_W-1){1'b1}}};
  localparam logic [DIN_W-1:0] SAT_NEG  = {1'b1, {(DIN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_r, nxt_state_s;
  logic [CNT_W-1:0] cnt_r, nxt_cnt_s;
  logic [NUM_W-1:0] num_r, nxt_num_s;
  logic [NUM_W-1:0] quo_r, nxt_quo_s;
  logic [W_W-1:0]   rem_r, nxt_rem_s;
  logic [W_W-1:0]   div_r, nxt_div_s;
  logic             sign_r, nxt_sign_s;
  logic             zero_r, nxt_zero_s;
  logic             din_neg_r, nxt_din_neg_s;
  logic             busy_r, nxt_busy_s;
  logic             done_r, nxt_done_s;
  logic [DIN_W-1:0] dout_r, nxt_dout_s;
  logic             sat_r, nxt_sat_s;
  logic             div_zero_r, nxt_div_zero_s;

  logic [DIN_W-1:0] din_abs_s;
  logic [W_W-1:0]   w_abs_s;
  logic [W_W:0]     trial_s;
  logic             fits_s;
  logic [W_W-1:0]   step_rem_s;
  logic [Q_W-1:0]   q_fix_s;

  // Magnitudes as unsigned values; the most negative input maps to 2^(n-1).
  assign din_abs_s = din[DIN_W-1] ? (~din + {{(DIN_W-1){1'b0}}, 1'b1}) : din;
  assign w_abs_s   = W[W_W-1] ? (~W + {{(W_W-1){1'b0}}, 1'b1}) : W;

  // Remainder stays below |W| (<= 2^(W_W-1)), so the restored value always fits W_W bits.
  assign trial_s    = {rem_r, num_r[NUM_W-1]};
  assign fits_s     = (trial_s >= {1'b0, div_r});
  assign step_rem_s = fits_s ? W_W'(trial_s - {1'b0, div_r}) : trial_s[W_W-1:0];

`ifdef DIVIDER_ROUND_EN
  logic round_s;
  assign round_s = ({rem_r, 1'b0} >= {1'b0, div_r}) && !zero_r;
  assign q_fix_s = {1'b0, quo_r} + {{NUM_W{1'b0}}, round_s};
`else
  assign q_fix_s = {1'b0, quo_r};
`endif

  // Next-state and next-output logic for the IDLE/DIV/FIX sequencer.
  always_comb begin
    nxt_state_s    = state_r;
    nxt_cnt_s      = cnt_r;
    nxt_num_s      = num_r;
    nxt_quo_s      = quo_r;
    nxt_rem_s      = rem_r;
    nxt_div_s      = div_r;
    nxt_sign_s     = sign_r;
    nxt_zero_s     = zero_r;
    nxt_din_neg_s  = din_neg_r;
    nxt_busy_s     = busy_r;
    nxt_done_s     = 1'b0;
    nxt_dout_s     = dout_r;
    nxt_sat_s      = sat_r;
    nxt_div_zero_s = div_zero_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          nxt_state_s   = DIV;
          nxt_busy_s    = 1'b1;
          nxt_cnt_s     = CNT_LOAD;
          nxt_num_s     = {din_abs_s, {FRAC{1'b0}}};
          nxt_quo_s     = {NUM_W{1'b0}};
          nxt_rem_s     = {W_W{1'b0}};
          nxt_div_s     = w_abs_s;
          nxt_sign_s    = din[DIN_W-1] ^ W[W_W-1];
          nxt_zero_s    = (W == {W_W{1'b0}});
          nxt_din_neg_s = din[DIN_W-1];
        end else begin
          nxt_state_s = IDLE;
        end
      end
      DIV: begin
        // Divide-by-zero runs the full step count too, keeping latency constant.
        nxt_num_s = {num_r[NUM_W-2:0], 1'b0};
        nxt_quo_s = {quo_r[NUM_W-2:0], fits_s};
        nxt_rem_s = step_rem_s;
        if (cnt_r == {CNT_W{1'b0}}) begin
          nxt_state_s = FIX;
        end else begin
          nxt_cnt_s = cnt_r - CNT_ONE;
        end
      end
      FIX: begin
        nxt_state_s = IDLE;
        nxt_busy_s  = 1'b0;
        nxt_done_s  = 1'b1;
        if (zero_r) begin
          nxt_dout_s     = din_neg_r ? SAT_NEG : SAT_POS;
          nxt_sat_s      = 1'b1;
          nxt_div_zero_s = 1'b1;
        end else if (!sign_r && (q_fix_s > POS_LIM)) begin
          nxt_dout_s     = SAT_POS;
          nxt_sat_s      = 1'b1;
          nxt_div_zero_s = 1'b0;
        end else if (sign_r && (q_fix_s > NEG_LIM)) begin
          nxt_dout_s     = SAT_NEG;
          nxt_sat_s      = 1'b1;
          nxt_div_zero_s = 1'b0;
        end else begin
          // Negating a zero magnitude yields 0, so there is no negative zero.
          nxt_dout_s     = sign_r ? -q_fix_s[DIN_W-1:0] : q_fix_s[DIN_W-1:0];
          nxt_sat_s      = 1'b0;
          nxt_div_zero_s = 1'b0;
        end
      end
      default: begin
        nxt_state_s = IDLE;
        nxt_busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      num_r      <= {NUM_W{1'b0}};
      quo_r      <= {NUM_W{1'b0}};
      rem_r      <= {W_W{1'b0}};
      div_r      <= {W_W{1'b0}};
      sign_r     <= 1'b0;
      zero_r     <= 1'b0;
      din_neg_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      dout_r     <= {DIN_W{1'b0}};
      sat_r      <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      cnt_r      <= nxt_cnt_s;
      num_r      <= nxt_num_s;
      quo_r      <= nxt_quo_s;
      rem_r      <= nxt_rem_s;
      div_r      <= nxt_div_s;
      sign_r     <= nxt_sign_s;
      zero_r     <= nxt_zero_s;
      din_neg_r  <= nxt_din_neg_s;
      busy_r     <= nxt_busy_s;
      done_r     <= nxt_done_s;
      dout_r     <= nxt_dout_s;
      sat_r      <= nxt_sat_s;
      div_zero_r <= nxt_div_zero_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign dout     = dout_r;
  assign sat      = sat_r;
  assign div_zero = div_zero_r;

endmodule
